// File: rtl/cic_ctrl_pkg.sv
// Shared definitions for the CIC decimator rate controller: controller states
// and the rate-select to decimation-ratio mapping.
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FLUSH = 2'd2,
        ST_RUN   = 2'd3
    } ctrl_state_t;

    localparam int unsigned CNT_W = 16;

    function automatic logic [CNT_W-1:0] decim_ratio(
        input logic [1:0]       sel,
        input logic [CNT_W-1:0] d0,
        input logic [CNT_W-1:0] d1,
        input logic [CNT_W-1:0] d2,
        input logic [CNT_W-1:0] d3
    );
        logic [CNT_W-1:0] ratio_v;
        case (sel)
            2'd0:    ratio_v = d0;
            2'd1:    ratio_v = d1;
            2'd2:    ratio_v = d2;
            2'd3:    ratio_v = d3;
            default: ratio_v = d0;
        endcase
        return ratio_v;
    endfunction

endpackage

// File: rtl/cic_decim_counter.sv
// Decimation counter with registered wrap pulse, plus the post-clear settle
// down-counter; both are reloaded by a single load strobe.
module cic_decim_counter #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        count,
    input  logic [15:0] ratio,
    input  logic        settle_dec,
    output logic        wrap,
    output logic [15:0] settle_cnt
);

    logic [15:0] decim_cnt_r;
    logic        wrap_r;
    logic [15:0] settle_cnt_r;

    // Decimation count: wraps on the ratio-th counted strobe and flags it for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            decim_cnt_r <= 16'd0;
            wrap_r      <= 1'b0;
        end else if (load) begin
            decim_cnt_r <= 16'd0;
            wrap_r      <= 1'b0;
        end else if (count) begin
            if (decim_cnt_r == (ratio - 16'd1)) begin
                decim_cnt_r <= 16'd0;
                wrap_r      <= 1'b1;
            end else begin
                decim_cnt_r <= decim_cnt_r + 16'd1;
                wrap_r      <= 1'b0;
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    // Settle count: number of decimated outputs still to be discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt_r <= 16'd0;
        end else if (load) begin
            settle_cnt_r <= 16'(SETTLE);
        end else if (settle_dec && (settle_cnt_r != 16'd0)) begin
            settle_cnt_r <= settle_cnt_r - 16'd1;
        end
    end

    assign wrap       = wrap_r;
    assign settle_cnt = settle_cnt_r;

endmodule

// File: rtl/cic_rate_ctrl.sv
// Rate controller for a CIC decimator: sequences clear, settle flush and run,
// and generates the integrator/comb strobes and the settled output-valid pulse.
module cic_rate_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned DECIM0 = 10,
    parameter int unsigned DECIM1 = 20,
    parameter int unsigned DECIM2 = 40,
    parameter int unsigned DECIM3 = 80,
    parameter int unsigned SETTLE = STAGES + 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    input  logic       rate_load,
    input  logic       in_valid,
    output logic       cic_in_strobe,
    output logic       cic_out_strobe,
    output logic       cic_clear,
    output logic       out_valid,
    output logic [1:0] rate_cur,
    output logic       busy
);

    ctrl_state_t state_r;
    ctrl_state_t next_state_s;

    logic        cic_in_strobe_r;
    logic        cic_out_strobe_r;
    logic        cic_clear_r;
    logic        out_valid_r;
    logic        busy_r;
    logic [1:0]  rate_cur_r;

    logic        active_s;
    logic        next_active_s;
    logic        fwd_s;
    logic        wrap_s;
    logic        settle_dec_s;
    logic        settle_done_s;
    logic [15:0] ratio_s;
    logic [15:0] settle_cnt_s;

    assign active_s      = (state_r == ST_FLUSH) || (state_r == ST_RUN);
    assign next_active_s = (next_state_s == ST_FLUSH) || (next_state_s == ST_RUN);
    // A sample coincident with a rate change is dropped so it never reaches the counter.
    assign fwd_s         = active_s && enable && !rate_load && in_valid;
    assign ratio_s       = decim_ratio(rate_cur_r, 16'(DECIM0), 16'(DECIM1),
                                       16'(DECIM2), 16'(DECIM3));
    assign settle_dec_s  = (state_r == ST_FLUSH) && cic_out_strobe_r;
    assign settle_done_s = (settle_cnt_s == 16'd0) ||
                           (settle_dec_s && (settle_cnt_s == 16'd1));

    cic_decim_counter #(
        .SETTLE (SETTLE)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (state_r == ST_CLEAR),
        .count      (fwd_s),
        .ratio      (ratio_s),
        .settle_dec (settle_dec_s),
        .wrap       (wrap_s),
        .settle_cnt (settle_cnt_s)
    );

    // Next-state selection: disable beats rate change, which beats normal progress.
    always_comb begin
        next_state_s = state_r;
        if (!enable) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  next_state_s = rate_load ? ST_IDLE : ST_CLEAR;
                ST_CLEAR: next_state_s = ST_FLUSH;
                ST_FLUSH: begin
                    if (rate_load) begin
                        next_state_s = ST_CLEAR;
                    end else if (settle_done_s) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_FLUSH;
                    end
                end
                ST_RUN:   next_state_s = rate_load ? ST_CLEAR : ST_RUN;
                default:  next_state_s = ST_IDLE;
            endcase
        end
    end

    // State register and all registered outputs, derived from the upcoming state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            rate_cur_r       <= 2'd0;
            cic_in_strobe_r  <= 1'b0;
            cic_out_strobe_r <= 1'b0;
            cic_clear_r      <= 1'b0;
            out_valid_r      <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (rate_load) begin
                rate_cur_r <= rate_sel;
            end
            cic_in_strobe_r  <= fwd_s;
            cic_out_strobe_r <= wrap_s && next_active_s;
            cic_clear_r      <= (next_state_s == ST_CLEAR);
            busy_r           <= (next_state_s == ST_CLEAR) || (next_state_s == ST_FLUSH);
            out_valid_r      <= cic_out_strobe_r && (state_r == ST_RUN) &&
                                (next_state_s == ST_RUN);
        end
    end

    assign cic_in_strobe  = cic_in_strobe_r;
    assign cic_out_strobe = cic_out_strobe_r;
    assign cic_clear      = cic_clear_r;
    assign out_valid      = out_valid_r;
    assign rate_cur       = rate_cur_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Self-checking bench for cic_rate_ctrl: directed scenarios plus randomized
// traffic, all compared every cycle against a sample-counting reference model.
module tb_cic_rate_ctrl;

    localparam int SETTLE_N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] rate_sel = 2'd0;
    logic       rate_load = 1'b0;
    logic       in_valid = 1'b0;
    logic       cic_in_strobe;
    logic       cic_out_strobe;
    logic       cic_clear;
    logic       out_valid;
    logic [1:0] rate_cur;
    logic       busy;
    logic [6:0] obs_s;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 clear, 2 flush, 3 run; counts samples since clear
    int         m_phase = 0;
    int         m_nf = 0;
    int         m_ns = 0;
    bit         m_dth = 1'b0;
    bit         e_in = 1'b0, e_out = 1'b0, e_clr = 1'b0, e_val = 1'b0, e_busy = 1'b0;
    logic [1:0] e_rate = 2'd0;

    cic_rate_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .rate_sel       (rate_sel),
        .rate_load      (rate_load),
        .in_valid       (in_valid),
        .cic_in_strobe  (cic_in_strobe),
        .cic_out_strobe (cic_out_strobe),
        .cic_clear      (cic_clear),
        .out_valid      (out_valid),
        .rate_cur       (rate_cur),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    assign obs_s = {cic_in_strobe, cic_out_strobe, cic_clear, out_valid, busy, rate_cur};

    function automatic int ratio(input logic [1:0] sel);
        case (sel)
            2'd0:    return 10;
            2'd1:    return 20;
            2'd2:    return 40;
            default: return 80;
        endcase
    endfunction

    function automatic logic [6:0] exp_v();
        return {e_in, e_out, e_clr, e_val, e_busy, e_rate};
    endfunction

    task automatic model_step();
        int nxt;
        bit fwd, cur_out, cur_dth;
        if (reset) begin
            m_phase = 0; m_nf = 0; m_ns = 0; m_dth = 1'b0;
            e_in = 1'b0; e_out = 1'b0; e_clr = 1'b0; e_val = 1'b0; e_busy = 1'b0;
            e_rate = 2'd0;
            return;
        end
        cur_out = e_out;
        cur_dth = m_dth;
        fwd = (m_phase >= 2) && enable && !rate_load && in_valid;
        if (!enable) nxt = 0;
        else begin
            case (m_phase)
                0: nxt = rate_load ? 0 : 1;
                1: nxt = 2;
                2: begin
                    if (rate_load) nxt = 1;
                    else begin
                        if (cur_out) m_ns++;
                        nxt = (m_ns >= SETTLE_N) ? 3 : 2;
                    end
                end
                default: nxt = rate_load ? 1 : 3;
            endcase
        end
        m_dth = 1'b0;
        if (fwd) begin
            m_nf++;
            m_dth = ((m_nf % ratio(e_rate)) == 0);
        end
        e_val  = cur_out && (m_phase == 3) && (nxt == 3);
        e_out  = cur_dth && (nxt >= 2);
        e_in   = fwd;
        e_clr  = (nxt == 1);
        e_busy = (nxt == 1) || (nxt == 2);
        if (rate_load) e_rate = rate_sel;
        if (nxt == 1) begin
            m_nf = 0;
            m_ns = 0;
        end
        m_phase = nxt;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1; in_valid = 1'b1; rate_load = 1'b1; rate_sel = 2'd3; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (obs_s !== 7'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b expected %b", obs_s, 7'd0);
            end
        end
        reset = 1'b0; rate_load = 1'b0; enable = 1'b0; in_valid = 1'b0;
        rate_sel = 2'd0;
    endtask

    task automatic test_settle();
        int n_clr = 0, n_out = 0, n_in = 0, cyc = 0;
        bit seen = 1'b0, prev_out = 1'b0;
        reset = 1'b1; cycle(); reset = 1'b0;
        enable = 1'b1; rate_sel = 2'd0;
        while (!seen && cyc < 600) begin
            in_valid = ((cyc % 4) == 3);
            prev_out = cic_out_strobe;
            cycle(); cyc++;
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL settle_model cyc %0d: got %b expected %b", cyc, obs_s, exp_v());
            end
            n_clr += int'(cic_clear);
            n_in  += int'(cic_in_strobe);
            if (out_valid) seen = 1'b1;
            else n_out += int'(cic_out_strobe);
        end
        vectors += 5;
        if (!seen) begin miscompares++; $display("FAIL settle_timeout: no out_valid in %0d cycles", cyc); end
        if (n_clr != 1) begin miscompares++; $display("FAIL settle_clears: got %0d expected 1", n_clr); end
        if (n_out != 5) begin miscompares++; $display("FAIL settle_strobes: got %0d expected 5", n_out); end
        if (n_in != 50) begin miscompares++; $display("FAIL settle_samples: got %0d expected 50", n_in); end
        if (prev_out !== 1'b1) begin miscompares++; $display("FAIL settle_latency: strobe before valid %b expected 1", prev_out); end
    endtask

    task automatic test_steady();
        int last = -1, n_str = 0, n_val = 0;
        in_valid = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            cycle();
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL steady_model cyc %0d: got %b expected %b", c, obs_s, exp_v());
            end
            if (out_valid) n_val++;
            if (cic_out_strobe) begin
                n_str++;
                if (last >= 0) begin
                    vectors++;
                    if (c - last != 10) begin
                        miscompares++;
                        $display("FAIL steady_gap: got %0d expected 10", c - last);
                    end
                end
                last = c;
            end
        end
        vectors += 2;
        if (n_str != 5) begin miscompares++; $display("FAIL steady_strobes: got %0d expected 5", n_str); end
        if (n_val != 5) begin miscompares++; $display("FAIL steady_valids: got %0d expected 5", n_val); end
    endtask

    task automatic test_rate_change();
        int n_in = 0, n_in_at_str = -1, n_clr = 0, cyc = 0;
        bit seen = 1'b0;
        in_valid = 1'b1; rate_load = 1'b1; rate_sel = 2'd2;
        cycle();
        rate_load = 1'b0;
        vectors++;
        if ({rate_cur, cic_clear, busy} !== 4'b1011) begin
            miscompares++;
            $display("FAIL rate_load_response: rate/clear/busy %b expected %b", {rate_cur, cic_clear, busy}, 4'b1011);
        end
        while (!seen && cyc < 3000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            cycle(); cyc++;
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL rate_model cyc %0d: got %b expected %b", cyc, obs_s, exp_v());
            end
            n_clr += int'(cic_clear);
            if (cic_out_strobe) n_in_at_str = n_in;
            n_in += int'(cic_in_strobe);
            if (out_valid) seen = 1'b1;
        end
        vectors += 3;
        if (!seen) begin miscompares++; $display("FAIL rate_timeout: no out_valid in %0d cycles", cyc); end
        if (n_in_at_str != 200) begin miscompares++; $display("FAIL rate_samples: got %0d expected 200", n_in_at_str); end
        if (n_clr != 0) begin miscompares++; $display("FAIL rate_extra_clear: got %0d expected 0", n_clr); end
    endtask

    task automatic test_drop_dth();
        reset = 1'b1; cycle(); reset = 1'b0;
        enable = 1'b1; rate_sel = 2'd0; in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            in_valid = (i >= 2);
            cycle();
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL drop_model step %0d: got %b expected %b", i, obs_s, exp_v());
            end
        end
        in_valid = 1'b1; rate_load = 1'b1;
        cycle();
        vectors++;
        if ({cic_in_strobe, cic_clear} !== 2'b01) begin
            miscompares++;
            $display("FAIL drop_in_strobe: in_strobe/clear %b expected %b", {cic_in_strobe, cic_clear}, 2'b01);
        end
        rate_load = 1'b0; in_valid = 1'b0;
        cycle();
        vectors++;
        if (cic_out_strobe !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_out_strobe: got %b expected 0", cic_out_strobe);
        end
    endtask

    task automatic test_enable_drop();
        int n_clr = 0, n_out = 0, cyc = 0;
        bit seen = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (obs_s !== 7'd0) begin
                miscompares++;
                $display("FAIL disable_outputs step %0d: got %b expected %b", i, obs_s, 7'd0);
            end
        end
        enable = 1'b1;
        while (!seen && cyc < 400) begin
            cycle(); cyc++;
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL reenable_model cyc %0d: got %b expected %b", cyc, obs_s, exp_v());
            end
            n_clr += int'(cic_clear);
            if (out_valid) seen = 1'b1;
            else n_out += int'(cic_out_strobe);
        end
        vectors += 3;
        if (!seen) begin miscompares++; $display("FAIL reenable_timeout: no out_valid in %0d cycles", cyc); end
        if (n_clr != 1) begin miscompares++; $display("FAIL reenable_clears: got %0d expected 1", n_clr); end
        if (n_out != 5) begin miscompares++; $display("FAIL reenable_strobes: got %0d expected 5", n_out); end
    endtask

    task automatic test_reset_mid_run();
        int cyc = 0;
        bit seen = 1'b0;
        enable = 1'b0; rate_load = 1'b1; rate_sel = 2'd3;
        cycle();
        rate_load = 1'b0;
        vectors++;
        if ({rate_cur, cic_clear, busy} !== 4'b1100) begin
            miscompares++;
            $display("FAIL idle_rate_load: rate/clear/busy %b expected %b", {rate_cur, cic_clear, busy}, 4'b1100);
        end
        enable = 1'b1; in_valid = 1'b1;
        while (!seen && cyc < 1000) begin
            cycle(); cyc++;
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL run80_model cyc %0d: got %b expected %b", cyc, obs_s, exp_v());
            end
            if (out_valid) seen = 1'b1;
        end
        for (int i = 0; i < 75; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        vectors += 2;
        if (!seen) begin miscompares++; $display("FAIL run80_timeout: no out_valid in %0d cycles", cyc); end
        if (obs_s !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got %b expected %b", obs_s, 7'd0);
        end
    endtask

    task automatic test_back_to_back();
        enable = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 30; i++) cycle();
        enable = 1'b0; rate_load = 1'b1; rate_sel = 2'd1;
        cycle();
        vectors++;
        if ({rate_cur, cic_clear, busy, cic_in_strobe} !== 5'b01000) begin
            miscompares++;
            $display("FAIL disable_with_load: rate/clear/busy/in %b expected %b",
                     {rate_cur, cic_clear, busy, cic_in_strobe}, 5'b01000);
        end
        enable = 1'b1; rate_load = 1'b0;
        for (int i = 0; i < 25; i++) cycle();
        for (int i = 0; i < 6; i++) begin
            rate_load = (i < 2); rate_sel = (i == 0) ? 2'd2 : 2'd3;
            cycle();
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, obs_s, exp_v());
            end
        end
        rate_load = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            rate_load = ($urandom_range(0, 149) == 0);
            rate_sel  = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            cycle();
            vectors++;
            if (obs_s !== exp_v()) begin
                miscompares++;
                $display("FAIL random_model cyc %0d: got %b expected %b", c, obs_s, exp_v());
            end
        end
        reset = 1'b0; rate_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_settle();
        test_steady();
        test_rate_change();
        test_drop_dth();
        test_enable_drop();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cic_rate_ctrl.md
CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 3: CIC stage count of the controlled decimator.
REQ-002 SHALL have parameters DECIM0..DECIM3, defaults 10, 20, 40, 80: decimation ratios selectable by rate_sel, each 2..65535.
REQ-003 SHALL have parameter SETTLE, default STAGES+1: decimated outputs discarded after each clear.
REQ-004 SHALL have ports, in this order:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- rate_sel  in  2  decimation select (0..3 maps to DECIM0..DECIM3).
- rate_load  in  1  one-cycle strobe that latches rate_sel.
- in_valid  in  1  ADC sample strobe.
- cic_in_strobe  out  1  integrator strobe to the CIC.
- cic_out_strobe  out  1  decimation strobe to the CIC combs.
- cic_clear  out  1  one-cycle clear of all CIC integrator and comb registers.
- out_valid  out  1  CIC output word is valid and settled.
- rate_cur  out  2  active rate select.
- busy  out  1  high in CLEAR or FLUSH.

Function
REQ-005 SHALL implement the states IDLE, CLEAR, FLUSH and RUN, all outputs registered.
REQ-006 IDLE: when enable=1, the next state SHALL be CLEAR.
REQ-007 CLEAR SHALL last exactly one cycle, with cic_clear=1, the decimation counter set to 0 and the settle counter set to SETTLE; the next state SHALL be FLUSH.
REQ-008 In FLUSH or RUN, cic_in_strobe SHALL follow in_valid one cycle later, gated by enable=1 and rate_load=0.
REQ-009 The decimation counter (16 bit) SHALL count forwarded strobes; on the D-th strobe (D = selected DECIMn) it SHALL wrap to 0, and cic_out_strobe SHALL pulse one cycle after that cic_in_strobe.
REQ-010 In FLUSH, each cic_out_strobe SHALL decrement the settle counter; when the counter reaches 0, the next state SHALL be RUN and no out_valid SHALL be produced for those SETTLE strobes.
REQ-011 In RUN, out_valid SHALL pulse exactly one cycle after each cic_out_strobe (comb output register latency).
REQ-012 rate_load in FLUSH or RUN SHALL latch rate_sel into rate_cur on the next edge and force CLEAR.
REQ-013 rate_load in IDLE SHALL latch rate_sel only, with the state staying IDLE.
REQ-014 enable=0 in any state SHALL force IDLE on the next edge; strobes and out_valid SHALL then be 0 from that cycle on.
REQ-015 If enable falls and rate_load is high in the same cycle, IDLE SHALL win and rate_sel SHALL still be latched.
REQ-016 An in_valid coincident with rate_load SHALL be dropped, including a D-th sample; no cic_out_strobe SHALL result from it.
REQ-017 busy SHALL be 1 exactly while the state is CLEAR or FLUSH.
REQ-018 A pending out_valid (the cycle after the last cic_out_strobe) SHALL be suppressed if the state left RUN in that cycle.

Reset
REQ-019 reset=1 SHALL, on the next edge, give state=IDLE, rate_cur=0, both counters=0, and cic_in_strobe, cic_out_strobe, cic_clear, out_valid and busy all 0.
REQ-020 reset SHALL take priority over all other inputs, including mid-FLUSH or mid-RUN.

Structure
REQ-021 The state encoding and the rate-select-to-ratio mapping function SHALL live in a shared package, cic_ctrl_pkg.
REQ-022 The decimation and settle counting SHALL be one sub-module, cic_decim_counter (load, count, wrap pulse); the FSM SHALL stay in cic_rate_ctrl.

Verification
REQ-023 Reset, enable=1, in_valid every 4th cycle, rate_sel=0 -> cic_clear pulses once; 4 cic_out_strobes with no out_valid; first out_valid one cycle after the strobe for sample 50.
REQ-024 In_valid every cycle in RUN -> cic_out_strobe exactly every 10 cycles, and out_valid 1 cycle after each strobe.
REQ-025 rate_load with rate_sel=2 in RUN -> rate_cur=2 next cycle, one cic_clear, busy=1, and first out_valid after 200 forwarded samples.
REQ-026 rate_load coincident with the 10th in_valid -> no cic_in_strobe and no cic_out_strobe for that sample.
REQ-027 enable=0 mid-FLUSH -> IDLE next cycle with busy=0 and no strobes; re-enable -> a fresh CLEAR and full settle.
REQ-028 reset mid-RUN with rate_cur=3 -> all outputs 0 and rate_cur=0 on the next cycle.
